// File: rtl/ecc_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : ecc_operand_loader
// Purpose  : Assembles a stream of WORD_W-bit host words into the DATA_W-bit
//            A and B operands of the ECC sequencer. It then presents them
//            with a one-cycle wr_reg strobe and, if the frame carries a
//            non-zero command, holds Seq_Command for CMD_HOLD cycles.
// Ports    : clk, rst_n               clock, asynchronous active-low reset
//            in_valid/in_ready/in_data host word handshake
//            op_cmd                   frame command, taken with the first word
//            seq_busy                 downstream busy, stalls the write strobe
//            Input_Data_A/B           registered operand buses
//            wr_reg                   one-cycle operand write strobe
//            Seq_Command              registered sequencer command (0 = none)
//            frame_done               one-cycle pulse in the last frame cycle
// Options  : ECC_LOADER_MSW_FIRST_EN  when defined, the first word of each
//                                     operand is the most significant one
// Revision : 1.0 - initial release
// ============================================================================
module ecc_operand_loader #(
    parameter int WORD_W   = 32,
    parameter int DATA_W   = 256,
    parameter int CMD_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [3:0]        op_cmd,
    input  logic              seq_busy,
    output logic [DATA_W-1:0] Input_Data_A,
    output logic [DATA_W-1:0] Input_Data_B,
    output logic              wr_reg,
    output logic [3:0]        Seq_Command,
    output logic              frame_done
);

    localparam int                WORDS     = DATA_W / WORD_W;
    localparam int                WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [3:0]        LAST_HOLD = 4'(CMD_HOLD - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_WRITE  = 2'd2,
        ST_CMD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [3:0]          hcnt_q, hcnt_d;
    logic [3:0]          cmd_q, cmd_d;
    logic                ready_en_q;
    logic [DATA_W-1:0]   stage_a_q, stage_a_d;
    logic [DATA_W-1:0]   stage_b_q, stage_b_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d;
    logic [DATA_W-1:0]   data_b_q, data_b_d;
    logic                wr_reg_q, wr_reg_d;
    logic [3:0]          seq_cmd_q, seq_cmd_d;
    logic                frame_done_q, frame_done_d;

    logic                w_accept;
    logic                w_last_word;
    logic                w_strobe;
    logic [WCNT_W-1:0]   w_widx;
    int                  w_base;

    // ready_en keeps in_ready low for the first cycle after reset release.
    assign in_ready    = ready_en_q && ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B));
    assign w_accept    = in_valid && in_ready;
    assign w_last_word = (wcnt_q == LAST_WORD);

`ifdef ECC_LOADER_MSW_FIRST_EN
    assign w_widx = LAST_WORD - wcnt_q;
`else
    assign w_widx = wcnt_q;
`endif
    assign w_base = int'(w_widx) * WORD_W;

    // The strobe can fire on the edge that takes the last B word (the new
    // word is forwarded through stage_b_d), or later from WRITE once
    // seq_busy is sampled low. wr_reg_q marks the strobe cycle itself.
    assign w_strobe = !seq_busy &&
                      (((state_q == ST_LOAD_B) && w_accept && w_last_word) ||
                       ((state_q == ST_WRITE) && !wr_reg_q));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        hcnt_d       = hcnt_q;
        cmd_d        = cmd_q;
        stage_a_d    = stage_a_q;
        stage_b_d    = stage_b_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        wr_reg_d     = 1'b0;
        seq_cmd_d    = 4'd0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_LOAD_A: begin
                if (w_accept) begin
                    stage_a_d[w_base +: WORD_W] = in_data;
                    if (wcnt_q == '0) begin
                        cmd_d = op_cmd;
                    end
                    if (w_last_word) begin
                        wcnt_d  = '0;
                        state_d = ST_LOAD_B;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (w_accept) begin
                    stage_b_d[w_base +: WORD_W] = in_data;
                    if (w_last_word) begin
                        wcnt_d  = '0;
                        state_d = ST_WRITE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_reg_q) begin
                    hcnt_d  = 4'd0;
                    state_d = (cmd_q != 4'd0) ? ST_CMD : ST_LOAD_A;
                end
            end
            ST_CMD: begin
                if (hcnt_q == LAST_HOLD) begin
                    hcnt_d  = 4'd0;
                    state_d = ST_LOAD_A;
                end else begin
                    hcnt_d = hcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
            end
        endcase

        if (w_strobe) begin
            wr_reg_d     = 1'b1;
            data_a_d     = stage_a_d;
            data_b_d     = stage_b_d;
            frame_done_d = (cmd_q == 4'd0);
        end

        // Outputs are registered, so they are derived from the next state:
        // Seq_Command is visible exactly in the CMD cycles.
        if (state_d == ST_CMD) begin
            seq_cmd_d = cmd_q;
            if (hcnt_d == LAST_HOLD) begin
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD_A;
            wcnt_q       <= '0;
            hcnt_q       <= 4'd0;
            cmd_q        <= 4'd0;
            ready_en_q   <= 1'b0;
            stage_a_q    <= '0;
            stage_b_q    <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            wr_reg_q     <= 1'b0;
            seq_cmd_q    <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            hcnt_q       <= hcnt_d;
            cmd_q        <= cmd_d;
            ready_en_q   <= 1'b1;
            stage_a_q    <= stage_a_d;
            stage_b_q    <= stage_b_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            wr_reg_q     <= wr_reg_d;
            seq_cmd_q    <= seq_cmd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Input_Data_A = data_a_q;
    assign Input_Data_B = data_b_q;
    assign wr_reg       = wr_reg_q;
    assign Seq_Command  = seq_cmd_q;
    assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_operand_loader
// Purpose  : Self-checking bench for ecc_operand_loader. Frame scenarios come
//            from a vector table; expected operands are queued when a frame
//            is driven and popped when the write strobe appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_operand_loader;

    localparam int WORD_W   = 32;
    localparam int DATA_W   = 256;
    localparam int CMD_HOLD = 2;
    localparam int WORDS    = DATA_W / WORD_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [3:0]        op_cmd;
    logic              seq_busy;
    logic [DATA_W-1:0] Input_Data_A;
    logic [DATA_W-1:0] Input_Data_B;
    logic              wr_reg;
    logic [3:0]        Seq_Command;
    logic              frame_done;

    ecc_operand_loader #(
        .WORD_W  (WORD_W),
        .DATA_W  (DATA_W),
        .CMD_HOLD(CMD_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .op_cmd      (op_cmd),
        .seq_busy    (seq_busy),
        .Input_Data_A(Input_Data_A),
        .Input_Data_B(Input_Data_B),
        .wr_reg      (wr_reg),
        .Seq_Command (Seq_Command),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] abase;
        logic [31:0] bbase;
        int          busy;
        bit          gapped;
        logic [3:0]  exp_cmd;
        bit          exp_done_with_wr;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        cmd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[5];
    vec_t vrst;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Operand word k is base+k; placement follows the build's word order.
    function automatic logic [DATA_W-1:0] pack(input logic [31:0] base);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) begin
`ifdef ECC_LOADER_MSW_FIRST_EN
            v[(WORDS-1-k)*WORD_W +: WORD_W] = base + 32'(k);
`else
            v[k*WORD_W +: WORD_W] = base + 32'(k);
`endif
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] c);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        op_cmd   = c;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        op_cmd   = 4'hE;
        if (!done) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input vec_t v);
        exp_t e;
        int   cyc;
        bit   got;
        e.a   = pack(v.abase);
        e.b   = pack(v.bbase);
        e.cmd = v.cmd;
        sb.push_back(e);
        seq_busy = (v.busy > 0);
        for (int k = 0; k < 2*WORDS; k++) begin
            // op_cmd carries junk after the first word; only word 0 counts.
            send_word((k < WORDS) ? v.abase + 32'(k) : v.bbase + 32'(k - WORDS),
                      (k == 0) ? v.cmd : ~v.cmd);
            if (v.gapped && (k % 2 == 0) && (k != 2*WORDS-1)) idle(2);
        end
        got = 1'b0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == v.busy) seq_busy = 1'b0;
            @(negedge clk);
            if (wr_reg) begin
                got = 1'b1;
                break;
            end
            chk("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        seq_busy = 1'b0;
        chk("wr_latency", 256'(cyc), 256'(v.busy + 1));
        if (got) begin
            e = sb.pop_front();
            chk("data_A", Input_Data_A, e.a);
            chk("data_B", Input_Data_B, e.b);
            chk("done_with_wr", frame_done, v.exp_done_with_wr);
            chk("cmd_during_wr", Seq_Command, 4'd0);
            chk("ready_during_wr", in_ready, 1'b0);
            if (v.exp_cmd != 4'd0) begin
                for (int h = 1; h <= CMD_HOLD; h++) begin
                    step();
                    chk("cmd_hold", Seq_Command, v.exp_cmd);
                    chk("cmd_done", frame_done, (h == CMD_HOLD));
                    chk("cmd_ready", in_ready, 1'b0);
                    chk("cmd_wr_off", wr_reg, 1'b0);
                    chk("cmd_A_held", Input_Data_A, e.a);
                end
            end
            step();
            chk("end_cmd_zero", Seq_Command, 4'd0);
            chk("end_ready", in_ready, 1'b1);
            chk("end_done_zero", frame_done, 1'b0);
            chk("end_wr_off", wr_reg, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cmd    A base        B base        busy gap  exp_cmd done_w_wr
        vecs[0] = '{4'h1, 32'h0000_0000, 32'h1000_0000, 0, 1'b0, 4'h1, 1'b0};
        vecs[1] = '{4'h0, 32'h0000_0000, 32'h1000_0000, 0, 1'b0, 4'h0, 1'b1};
        vecs[2] = '{4'hA, 32'hA5A5_0000, 32'h5A5A_0100, 5, 1'b0, 4'hA, 1'b0};
        vecs[3] = '{4'h1, 32'h0000_0000, 32'h1000_0000, 0, 1'b1, 4'h1, 1'b0};
        vecs[4] = '{4'h0, 32'hCAFE_1230, 32'h7777_0FF0, 1, 1'b1, 4'h0, 1'b1};
        vrst    = '{4'h3, 32'h3300_0040, 32'h4400_0080, 0, 1'b0, 4'h3, 1'b0};

        // Reset held with in_valid asserted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        op_cmd   = 4'h5;
        seq_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wr_reg", wr_reg, 1'b0);
        chk("rst_seq_cmd", Seq_Command, 4'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_data_A", Input_Data_A, '0);
        chk("rst_data_B", Input_Data_B, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_cycle1", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_ready_cycle2", in_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
        end

        // Reset after five A words, then a fresh frame with command 3.
        for (int k = 0; k < 5; k++) begin
            send_word(32'h0BAD_0000 + 32'(k), 4'h7);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_data_A", Input_Data_A, '0);
        chk("midrst_data_B", Input_Data_B, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(vrst);

        chk("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
